// File: rtl/fifo_bank_reader.sv
// Round-robin drain of a multi-lane byte FIFO bank into a single ordered byte stream.
// Reads are credit-limited so the 2-entry output buffer can never overflow.
module fifo_bank_reader #(
   parameter int LANES = 10,
   parameter int DW    = 8,
   parameter int CNT_W = 16
) (
   input  logic                clk_dwt,
   input  logic                rst,
   input  logic                rst_syn,
   input  logic [LANES-1:0]    rdempty,
   input  logic [LANES*DW-1:0] fifo_q,
   output logic [LANES-1:0]    rdreq,
   input  logic                flush,
   output logic [DW-1:0]       byte_out,
   output logic                byte_vld,
   input  logic                byte_rdy,
   output logic                drain_done,
   output logic [CNT_W-1:0]    byte_cnt
);

   localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(LANES - 1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_FLUSH,
      ST_DONE
   } state_t;

   state_t            r_state;
   state_t            w_stateNext;
   logic [PTR_W-1:0]  r_rdPtr;
   logic [PTR_W-1:0]  r_capLane;
   logic              r_inflight;
   logic [1:0]        r_occ;
   logic [DW-1:0]     r_byteOut;
   logic [DW-1:0]     r_tail;
   logic              r_byteVld;
   logic [CNT_W-1:0]  r_byteCnt;

   logic              w_accept;
   logic              w_issue;
   logic [1:0]        w_occAfterPop;
   logic [1:0]        w_occNext;
   logic [DW-1:0]     w_capByte;
   logic [DW-1:0]     w_headAfterPop;
   logic [DW-1:0]     w_headNext;
   logic [DW-1:0]     w_tailNext;
   logic [LANES-1:0]  w_rdReq;
   logic              w_drainDone;
   logic              w_segmentEmpty;

   assign w_accept  = r_byteVld & byte_rdy;
   assign w_capByte = fifo_q[int'(r_capLane)*DW +: DW];

   // Credit counts the buffer after this cycle's pop, which is what lets a
   // full-rate stream issue a read every cycle while a byte is being accepted.
   assign w_occAfterPop = r_occ - {1'b0, w_accept};
   assign w_issue = rst && !rst_syn && !rdempty[r_rdPtr] &&
                    ((w_occAfterPop + {1'b0, r_inflight}) < 2'd2);

   always_comb begin
      w_rdReq = '0;
      w_rdReq[r_rdPtr] = w_issue;
   end

   always_comb begin
      w_headAfterPop = (w_accept && (r_occ == 2'd2)) ? r_tail : r_byteOut;
      w_headNext     = w_headAfterPop;
      w_tailNext     = r_tail;
      w_occNext      = w_occAfterPop + {1'b0, r_inflight};
      if (r_inflight) begin
         if (w_occAfterPop == 2'd0) begin
            w_headNext = w_capByte;
         end else begin
            w_tailNext = w_capByte;
         end
      end
   end

   assign w_segmentEmpty = rdempty[r_rdPtr] && !r_inflight &&
                           (r_occ == 2'd0) && !r_byteVld;

   always_comb begin
      w_stateNext = r_state;
      w_drainDone = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (flush) begin
               w_stateNext = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (w_segmentEmpty) begin
               w_stateNext = ST_DONE;
            end
         end
         ST_DONE: begin
            w_drainDone = 1'b1;
            w_stateNext = ST_RUN;
         end
         default: begin
            w_stateNext = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk_dwt or negedge rst) begin
      if (!rst) begin
         r_state <= ST_RUN;
      end else if (rst_syn) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Pointer never rewinds at segment end: the writer's start lane persists too.
   always_ff @(posedge clk_dwt or negedge rst) begin
      if (!rst) begin
         r_rdPtr    <= '0;
         r_capLane  <= '0;
         r_inflight <= 1'b0;
      end else if (rst_syn) begin
         r_rdPtr    <= '0;
         r_capLane  <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_capLane <= r_rdPtr;
            r_rdPtr   <= (r_rdPtr == LAST_LANE) ? '0 : r_rdPtr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_dwt or negedge rst) begin
      if (!rst) begin
         r_occ     <= '0;
         r_byteOut <= '0;
         r_tail    <= '0;
         r_byteVld <= 1'b0;
      end else if (rst_syn) begin
         r_occ     <= '0;
         r_byteOut <= '0;
         r_tail    <= '0;
         r_byteVld <= 1'b0;
      end else begin
         r_occ     <= w_occNext;
         r_byteOut <= w_headNext;
         r_tail    <= w_tailNext;
         r_byteVld <= (w_occNext != 2'd0);
      end
   end

   // A byte accepted in the DONE cycle already belongs to the next segment.
   always_ff @(posedge clk_dwt or negedge rst) begin
      if (!rst) begin
         r_byteCnt <= '0;
      end else if (rst_syn) begin
         r_byteCnt <= '0;
      end else if (r_state == ST_DONE) begin
         r_byteCnt <= CNT_W'(w_accept);
      end else if (w_accept && (r_byteCnt != '1)) begin
         r_byteCnt <= r_byteCnt + 1'b1;
      end
   end

   assign rdreq      = w_rdReq;
   assign byte_out   = r_byteOut;
   assign byte_vld   = r_byteVld;
   assign drain_done = w_drainDone;
   assign byte_cnt   = r_byteCnt;

endmodule

// File: tb/tb_fifo_bank_reader.sv
// Directed bench for fifo_bank_reader with a behavioural 10-lane FIFO bank model.
module tb_fifo_bank_reader;

   localparam int LANES = 10;
   localparam int DW    = 8;
   localparam int CNT_W = 16;

   logic                clk;
   logic                rst;
   logic                rst_syn;
   logic [LANES-1:0]    rdempty;
   logic [LANES*DW-1:0] fifo_q;
   logic [LANES-1:0]    rdreq;
   logic                flush;
   logic [DW-1:0]       byte_out;
   logic                byte_vld;
   logic                byte_rdy;
   logic                drain_done;
   logic [CNT_W-1:0]    byte_cnt;

   int vectors;
   int miscompares;
   int badRead;

   logic [7:0] laneMem [LANES][16];
   int         wrCnt [LANES];
   int         rdCnt [LANES];
   logic [7:0] acceptQ [$];
   int         readQ [$];

   fifo_bank_reader #(.LANES(LANES), .DW(DW), .CNT_W(CNT_W)) dut (
      .clk_dwt    (clk),
      .rst        (rst),
      .rst_syn    (rst_syn),
      .rdempty    (rdempty),
      .fifo_q     (fifo_q),
      .rdreq      (rdreq),
      .flush      (flush),
      .byte_out   (byte_out),
      .byte_vld   (byte_vld),
      .byte_rdy   (byte_rdy),
      .drain_done (drain_done),
      .byte_cnt   (byte_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < LANES; g++) begin : gEmpty
      assign rdempty[g] = (wrCnt[g] == rdCnt[g]);
   end

   // Lane FIFO model: data appears one cycle after the read request.
   initial fifo_q = '0;
   initial for (int i = 0; i < LANES; i++) rdCnt[i] = 0;
   always @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (rdreq[i]) begin
            fifo_q[i*DW +: DW] <= laneMem[i][rdCnt[i] % 16];
            rdCnt[i] <= rdCnt[i] + 1;
         end
      end
   end

   always begin
      @(negedge clk);
      #2;
      if (byte_vld && byte_rdy && !rst_syn) acceptQ.push_back(byte_out);
      if ($countones(rdreq) > 1) badRead++;
      for (int i = 0; i < LANES; i++) begin
         if (rdreq[i]) begin
            readQ.push_back(i);
            if (rdempty[i]) badRead++;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pushByte(input int lane, input logic [7:0] val);
      laneMem[lane][wrCnt[lane] % 16] = val;
      wrCnt[lane] = wrCnt[lane] + 1;
   endtask

   task automatic applyStimulus(input logic rdy, input logic fl, input logic syn);
      byte_rdy = rdy;
      flush    = fl;
      rst_syn  = syn;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clearLogs();
      acceptQ.delete();
      readQ.delete();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      badRead     = 0;
      for (int i = 0; i < LANES; i++) wrCnt[i] = 0;
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < LANES; i++) pushByte(i, 8'(8'h10 + i));

      $display("[TB] reset with all lanes non-empty");
      tick(3);
      #1;
      checkOutput("rst_rdreq", 32'(rdreq), 32'h0);
      checkOutput("rst_vld", 32'(byte_vld), 32'h0);
      checkOutput("rst_cnt", 32'(byte_cnt), 32'h0);
      checkOutput("rst_done", 32'(drain_done), 32'h0);

      $display("[TB] ordered drain 0x10..0x19");
      tick(1);
      rst = 1'b1;
      for (int k = 0; k <= 12; k++) begin
         #1;
         checkOutput($sformatf("drain_rdreq_%0d", k), 32'(rdreq), (k < 10) ? (32'h1 << k) : 32'h0);
         checkOutput($sformatf("drain_vld_%0d", k), 32'(byte_vld), (k >= 2 && k <= 11) ? 32'h1 : 32'h0);
         if (k >= 2 && k <= 11)
            checkOutput($sformatf("drain_byte_%0d", k), 32'(byte_out), 32'(8'h10 + k - 2));
         tick(1);
      end
      checkOutput("drain_cnt", 32'(byte_cnt), 32'd10);

      $display("[TB] wrap and stall on empty lane 0");
      for (int i = 0; i < 8; i++) pushByte(i, 8'(8'h20 + i));
      tick(12);
      clearLogs();
      pushByte(8, 8'hA8);
      pushByte(9, 8'hA9);
      pushByte(1, 8'hC1);
      tick(4);
      #1;
      checkOutput("wrap_stall_rdreq", 32'(rdreq), 32'h0);
      checkOutput("wrap_gap_vld", 32'(byte_vld), 32'h0);
      tick(1);
      pushByte(0, 8'hB0);
      tick(8);
      checkOutput("wrap_nbytes", 32'(acceptQ.size()), 32'd4);
      checkOutput("wrap_nreads", 32'(readQ.size()), 32'd4);
      if (acceptQ.size() == 4 && readQ.size() == 4) begin
         checkOutput("wrap_b0", 32'(acceptQ[0]), 32'hA8);
         checkOutput("wrap_b1", 32'(acceptQ[1]), 32'hA9);
         checkOutput("wrap_b2", 32'(acceptQ[2]), 32'hB0);
         checkOutput("wrap_b3", 32'(acceptQ[3]), 32'hC1);
         checkOutput("wrap_lane2", 32'(readQ[2]), 32'd0);
         checkOutput("wrap_lane3", 32'(readQ[3]), 32'd1);
      end

      $display("[TB] backpressure");
      clearLogs();
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < LANES; i++) pushByte(i, 8'(8'h40 + i));
      tick(5);
      #1;
      checkOutput("bp_vld", 32'(byte_vld), 32'h1);
      checkOutput("bp_byte_early", 32'(byte_out), 32'h42);
      tick(14);
      #1;
      checkOutput("bp_byte_late", 32'(byte_out), 32'h42);
      checkOutput("bp_nreads", 32'(readQ.size()), 32'd2);
      checkOutput("bp_rdreq", 32'(rdreq), 32'h0);
      tick(1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick(15);
      checkOutput("bp_nbytes", 32'(acceptQ.size()), 32'd10);
      if (acceptQ.size() == 10) begin
         for (int j = 0; j < 10; j++)
            checkOutput($sformatf("bp_byte_%0d", j), 32'(acceptQ[j]), 32'(8'h40 + ((j + 2) % 10)));
      end

      $display("[TB] synchronous clear with data buffered and in flight");
      clearLogs();
      applyStimulus(1'b0, 1'b0, 1'b0);
      pushByte(2, 8'h62);
      pushByte(3, 8'h63);
      tick(2);
      #1;
      checkOutput("syn_pre_vld", 32'(byte_vld), 32'h1);
      checkOutput("syn_pre_byte", 32'(byte_out), 32'h62);
      applyStimulus(1'b0, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("syn_vld", 32'(byte_vld), 32'h0);
      checkOutput("syn_byte", 32'(byte_out), 32'h0);
      checkOutput("syn_cnt", 32'(byte_cnt), 32'h0);
      checkOutput("syn_rdreq", 32'(rdreq), 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick(5);
      checkOutput("syn_stray", 32'(acceptQ.size()), 32'd0);
      checkOutput("syn_nreads", 32'(readQ.size()), 32'd2);

      $display("[TB] flush with 7 bytes pending");
      clearLogs();
      for (int i = 0; i < 7; i++) pushByte(i, 8'(8'h70 + i));
      applyStimulus(1'b1, 1'b1, 1'b0);
      for (int k = 0; k <= 11; k++) begin
         #1;
         checkOutput($sformatf("flush_done_%0d", k), 32'(drain_done), (k == 10) ? 32'h1 : 32'h0);
         if (k == 10) checkOutput("flush_cnt_done", 32'(byte_cnt), 32'd7);
         if (k == 11) checkOutput("flush_cnt_after", 32'(byte_cnt), 32'd0);
         tick(1);
         if (k == 0) applyStimulus(1'b1, 1'b0, 1'b0);
      end
      checkOutput("flush_nbytes", 32'(acceptQ.size()), 32'd7);
      if (acceptQ.size() == 7) begin
         for (int j = 0; j < 7; j++)
            checkOutput($sformatf("flush_byte_%0d", j), 32'(acceptQ[j]), 32'(8'h70 + j));
      end

      $display("[TB] flush with nothing pending");
      applyStimulus(1'b1, 1'b1, 1'b0);
      #1;
      checkOutput("eflush_p0", 32'(drain_done), 32'h0);
      tick(1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      #1;
      checkOutput("eflush_p1", 32'(drain_done), 32'h0);
      tick(1);
      #1;
      checkOutput("eflush_p2", 32'(drain_done), 32'h1);
      tick(1);
      #1;
      checkOutput("eflush_p3", 32'(drain_done), 32'h0);

      $display("[TB] read pointer kept across segment end");
      clearLogs();
      pushByte(0, 8'h80);
      pushByte(7, 8'h87);
      tick(6);
      checkOutput("ptr_nreads", 32'(readQ.size()), 32'd1);
      checkOutput("ptr_nbytes", 32'(acceptQ.size()), 32'd1);
      if (readQ.size() == 1 && acceptQ.size() == 1) begin
         checkOutput("ptr_lane", 32'(readQ[0]), 32'd7);
         checkOutput("ptr_byte", 32'(acceptQ[0]), 32'h87);
      end

      checkOutput("read_protocol", 32'(badRead), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
